// File: rtl/sensor_pkg.sv
// Shared types, command/response codes and helpers for the sensor result packer.
package sensor_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 23;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHECK     = 3'd4,
    ST_SEND0     = 3'd5,
    ST_SEND1     = 3'd6
  } state_t;

  localparam logic [BYTE_W-1:0] CMD_STATUS   = 8'h00;
  localparam logic [BYTE_W-1:0] CMD_TEMP     = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_HUMIDITY = 8'h02;

  localparam logic [BYTE_W-1:0] RESP_OK      = 8'h00;
  localparam logic [BYTE_W-1:0] RESP_TEMP    = 8'h09;
  localparam logic [BYTE_W-1:0] RESP_HUM     = 8'h0A;
  localparam logic [BYTE_W-1:0] RESP_ERR     = 8'h1F;
  localparam logic [BYTE_W-1:0] RESP_UNKNOWN = 8'hEE;

  // Decoder bytes arrive LSB-first; flip them into normal bit order.
  function automatic logic [BYTE_W-1:0] bit_rev8(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] r;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      r[i] = b[BYTE_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sensor_checksum.sv
// Bit-corrects the raw decoder bytes and checks the 8-bit additive checksum.
module sensor_checksum
  import sensor_pkg::*;
(
  input  logic [BYTE_W-1:0] hum_int,
  input  logic [BYTE_W-1:0] hum_float,
  input  logic [BYTE_W-1:0] temp_int,
  input  logic [BYTE_W-1:0] temp_float,
  input  logic [BYTE_W-1:0] crc,
  output logic [BYTE_W-1:0] hum_c,
  output logic [BYTE_W-1:0] temp_c,
  output logic              ok_c
);

  logic [BYTE_W-1:0] hum_f;
  logic [BYTE_W-1:0] temp_f;
  logic [BYTE_W-1:0] crc_r;
  logic [BYTE_W-1:0] sum;

  // Reverse each byte, then compare the carry-dropped sum with the checksum.
  always_comb begin
    hum_c  = bit_rev8(hum_int);
    hum_f  = bit_rev8(hum_float);
    temp_c = bit_rev8(temp_int);
    temp_f = bit_rev8(temp_float);
    crc_r  = bit_rev8(crc);
    sum    = BYTE_W'(hum_c + hum_f + temp_c + temp_f);
    ok_c   = (sum == crc_r);
  end

endmodule

// File: rtl/sensor_result_packer.sv
// Runs one DHT decoder read per command and returns a two-byte response.
module sensor_result_packer
  import sensor_pkg::*;
#(
  parameter int unsigned BUSY_TMO = 16,
  parameter int unsigned DONE_TMO = 8_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [BYTE_W-1:0] cmd,
  output logic              cmd_ready,
  output logic              dec_en,
  output logic              dec_rst,
  input  logic [BYTE_W-1:0] hum_int,
  input  logic [BYTE_W-1:0] hum_float,
  input  logic [BYTE_W-1:0] temp_int,
  input  logic [BYTE_W-1:0] temp_float,
  input  logic [BYTE_W-1:0] crc,
  input  logic              dec_wait,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TMO - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TMO - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BYTE_W-1:0] cmd_q, cmd_n;
  logic              unk_q, unk_n;
  logic              err_q, err_n;
  logic [BYTE_W-1:0] temp_res, temp_res_n;
  logic [BYTE_W-1:0] hum_res, hum_res_n;
  logic [BYTE_W-1:0] resp0, resp1;
  logic [BYTE_W-1:0] tx_data_n;
  logic              dec_en_n;
  logic [BYTE_W-1:0] hum_c, temp_c;
  logic              ok_c;

  sensor_checksum u_checksum (
    .hum_int   (hum_int),
    .hum_float (hum_float),
    .temp_int  (temp_int),
    .temp_float(temp_float),
    .crc       (crc),
    .hum_c     (hum_c),
    .temp_c    (temp_c),
    .ok_c      (ok_c)
  );

  // State, context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd_q     <= '0;
      unk_q     <= 1'b0;
      err_q     <= 1'b0;
      temp_res  <= '0;
      hum_res   <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      dec_en    <= 1'b0;
      dec_rst   <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd_q     <= cmd_n;
      unk_q     <= unk_n;
      err_q     <= err_n;
      temp_res  <= temp_res_n;
      hum_res   <= hum_res_n;
      cmd_ready <= (state_n == ST_IDLE);
      busy      <= (state_n != ST_IDLE);
      dec_en    <= dec_en_n;
      dec_rst   <= (state_n == ST_START);
      tx_valid  <= (state_n == ST_SEND0) || (state_n == ST_SEND1);
      tx_data   <= tx_data_n;
    end
  end

  // Next-state, flag/result updates and next output values.
  always_comb begin
    state_n    = state;
    cmd_n      = cmd_q;
    unk_n      = unk_q;
    err_n      = err_q;
    temp_res_n = temp_res;
    hum_res_n  = hum_res;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          err_n = 1'b0;
          if (cmd <= CMD_HUMIDITY) begin
            cmd_n   = cmd;
            unk_n   = 1'b0;
            state_n = ST_START;
          end else begin
            unk_n   = 1'b1;
            state_n = ST_SEND0;
          end
        end
      end
      ST_START: state_n = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (dec_wait) begin
          state_n = ST_WAIT_DONE;
        end else if (cnt == BUSY_LAST) begin
          err_n   = 1'b1;
          state_n = ST_SEND0;
        end
      end
      ST_WAIT_DONE: begin
        if (!dec_wait) begin
          state_n = ST_CHECK;
        end else if (cnt == DONE_LAST) begin
          err_n   = 1'b1;
          state_n = ST_SEND0;
        end
      end
      ST_CHECK: begin
        if (ok_c) begin
          err_n      = 1'b0;
          temp_res_n = temp_c;
          hum_res_n  = hum_c;
        end else begin
          err_n = 1'b1;
        end
        state_n = ST_SEND0;
      end
      ST_SEND0: if (tx_ready) state_n = ST_SEND1;
      ST_SEND1: if (tx_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    cnt_n    = (state_n != state) ? '0 : CNT_W'(cnt + 1'b1);
    dec_en_n = (state_n == ST_START) || (dec_en && (state_n != ST_IDLE));

    // Response pair selected from the flags as they will stand next cycle.
    if (unk_n) begin
      resp0 = RESP_UNKNOWN;
      resp1 = '0;
    end else if (err_n) begin
      resp0 = RESP_ERR;
      resp1 = '0;
    end else if (cmd_n == CMD_TEMP) begin
      resp0 = RESP_TEMP;
      resp1 = temp_res_n;
    end else if (cmd_n == CMD_HUMIDITY) begin
      resp0 = RESP_HUM;
      resp1 = hum_res_n;
    end else begin
      resp0 = RESP_OK;
      resp1 = '0;
    end

    case (state_n)
      ST_SEND0: tx_data_n = resp0;
      ST_SEND1: tx_data_n = resp1;
      default:  tx_data_n = '0;
    endcase
  end

endmodule

// File: tb/tb_sensor_result_packer.sv
// Directed scoreboard bench for sensor_result_packer with a simple decoder model.
module tb_sensor_result_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       cmd_ready;
  logic       dec_en;
  logic       dec_rst;
  logic [7:0] hum_int = 8'hEC;
  logic [7:0] hum_float = 8'h00;
  logic [7:0] temp_int = 8'h98;
  logic [7:0] temp_float = 8'h00;
  logic [7:0] crc = 8'h0A;
  logic       dec_wait = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  bit         dec_model_on = 1'b1;
  int         dec_rst_count = 0;

  sensor_result_packer #(.BUSY_TMO(16), .DONE_TMO(8_000_000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .dec_en    (dec_en),
    .dec_rst   (dec_rst),
    .hum_int   (hum_int),
    .hum_float (hum_float),
    .temp_int  (temp_int),
    .temp_float(temp_float),
    .crc       (crc),
    .dec_wait  (dec_wait),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  // Decoder model: WAIT rises a cycle after the start pulse and falls 100 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dec_rst) begin
        dec_rst_count++;
        if (dec_model_on) begin
          @(posedge clk); #1 dec_wait = 1'b1;
          repeat (100) @(posedge clk);
          #1 dec_wait = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted TX byte is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tx got=%02h required=none", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_cmd(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b1; cmd = c;
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && cmd_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_pair(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
  endtask

  initial begin
    int  n;
    int  c0;
    bit  stable;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dec_en", 32'(dec_en), 32'd0);
    check("rst_dec_rst", 32'(dec_rst), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    // WAIT toggling in IDLE must do nothing
    dec_wait = 1'b1;
    repeat (3) @(posedge clk);
    #1 dec_wait = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_wait_busy", 32'(busy), 32'd0);

    // Temperature read, good checksum
    push_pair(8'h09, 8'h19);
    send_cmd(8'h01);
    repeat (20) @(negedge clk);
    check("temp_dec_en", 32'(dec_en), 32'd1);
    check("temp_busy", 32'(busy), 32'd1);
    check("temp_cmd_ready", 32'(cmd_ready), 32'd0);
    wait_idle("temp_drain");
    check("temp_dec_en_idle", 32'(dec_en), 32'd0);

    // Humidity read, bad checksum, then status
    crc = 8'h0B;
    push_pair(8'h1F, 8'h00);
    send_cmd(8'h02);
    wait_idle("hum_bad_drain");
    push_pair(8'h1F, 8'h00);
    send_cmd(8'h00);
    wait_idle("status_bad_drain");

    // Good checksum again: status OK and humidity value
    crc = 8'h0A;
    push_pair(8'h00, 8'h00);
    send_cmd(8'h00);
    wait_idle("status_ok_drain");
    push_pair(8'h0A, 8'h37);
    send_cmd(8'h02);
    wait_idle("hum_ok_drain");

    // WAIT never rises: 16 cycles in WAIT_BUSY then error response
    dec_model_on = 1'b0;
    push_pair(8'h1F, 8'h00);
    send_cmd(8'h01);
    @(negedge clk);
    check("tmo_dec_rst", 32'(dec_rst), 32'd1);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", 32'(n), 32'd17);
    wait_idle("tmo_drain");
    dec_model_on = 1'b1;

    // Unknown command: no decoder start
    c0 = dec_rst_count;
    push_pair(8'hEE, 8'h00);
    send_cmd(8'h07);
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("unk_dec_en", 32'(dec_en), 32'd0);
    wait_idle("unk_drain");
    check("unk_dec_rst_count", 32'(dec_rst_count), 32'(c0));

    // TX stall for 50 cycles with a dropped command
    tx_ready = 1'b0;
    push_pair(8'h09, 8'h19);
    send_cmd(8'h01);
    n = 0;
    while (!tx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(tx_valid && tx_data == 8'h09 && !cmd_ready)) stable = 1'b0;
      if (i == 10) begin
        cmd_valid = 1'b1;
        cmd = 8'h02;
      end
      if (i == 11) cmd_valid = 1'b0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    tx_ready = 1'b1;
    wait_idle("stall_drain");
    repeat (150) @(negedge clk);
    check("stall_no_queue", 32'(busy), 32'd0);

    // Reset in WAIT_DONE
    send_cmd(8'h01);
    n = 0;
    while (!dec_wait && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_dec_en", 32'(dec_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sensor_result_packer.md
SENSOR_RESULT_PACKER -- requirements
Module: sensor_result_packer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter BUSY_TMO, default 16, meaning the maximum cycles to wait for WAIT to rise after a start pulse.
REQ-003 SHALL have parameter DONE_TMO, default 8_000_000, meaning the maximum cycles to wait for WAIT to fall.
REQ-004 CLK  in  1  system clock (50 MHz).
REQ-005 RST  in  1  asynchronous reset, active-low.
REQ-006 CMD_VALID  in  1  command byte present.
REQ-007 CMD  in  8  command: 0x00 status, 0x01 temperature, 0x02 humidity.
REQ-008 CMD_READY  out  1  high only in IDLE.
REQ-009 DEC_EN  out  1  enable to the upstream DHT decoder.
REQ-010 DEC_RST  out  1  one-cycle, active-high start pulse to the decoder.
REQ-011 HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC  in  8 each  raw decoder bytes, bit-reversed (bit 0 holds the first received bit).
REQ-012 WAIT  in  1  decoder busy flag.
REQ-013 TX_DATA  out  8  response byte.
REQ-014 TX_VALID  out  1  response byte valid.
REQ-015 TX_READY  in  1  downstream UART transmitter accepts the byte.
REQ-016 BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-017 States SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE, CHECK, SEND0, SEND1.
REQ-018 IDLE: on CMD_VALID with CMD ≤ 0x02, the block SHALL latch CMD and go to START; on any other CMD it SHALL latch the "unknown" flag and go to SEND0.
REQ-019 START: DEC_EN=1 and DEC_RST=1 for exactly one cycle, then WAIT_BUSY; DEC_EN SHALL stay 1 until the block returns to IDLE.
REQ-020 WAIT_BUSY: on WAIT=1 go to WAIT_DONE; if the counter reaches BUSY_TMO, set sensor error and go to SEND0.
REQ-021 WAIT_DONE: on WAIT=0 go to CHECK; if the counter reaches DONE_TMO, set sensor error and go to SEND0.
REQ-022 The cycle counter SHALL be 23 bits and SHALL clear on every state change.
REQ-023 CHECK (1 cycle): bit-reverse every input byte, then sensor OK SHALL be true iff (hum_i + hum_f + temp_i + temp_f) mod 256 == crc, computed at 8-bit width with the carry dropped; then go to SEND0.
REQ-024 On sensor OK, the corrected temp_i and hum_i SHALL be stored in result registers.
REQ-025 On a sensor error the result registers SHALL be left unchanged.
REQ-026 Response pairs (byte0, byte1):
  - status: (0x00, 0x00) if OK, else (0x1F, 0x00)
  - temperature: (0x09, temp_i) if OK, else (0x1F, 0x00)
  - humidity: (0x0A, hum_i) if OK, else (0x1F, 0x00)
  - unknown command: (0xEE, 0x00)
REQ-027 SEND0 and SEND1: TX_VALID=1 with TX_DATA stable until the cycle in which TX_READY=1; SEND0 then advances to SEND1, and SEND1 advances to IDLE.
REQ-028 TX_READY held low SHALL stall the block indefinitely with no timeout.
REQ-029 CMD_VALID while CMD_READY=0 SHALL be ignored and never queued.
REQ-030 In IDLE, WAIT toggling SHALL have no effect.
REQ-031 Latency: CHECK SHALL be entered one cycle after the cycle in which WAIT is sampled low; SEND0 SHALL be entered the cycle after CHECK.

Reset
REQ-032 On RST=0 the block SHALL enter IDLE and set all outputs to 0 except CMD_READY, which SHALL be 1.
REQ-033 On RST=0 the counter, result registers and flags SHALL clear to 0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no partial TX byte; DEC_EN SHALL drop in the same cycle.

Structure
REQ-035 A shared package sensor_pkg SHALL hold the state enum, the command codes (0x00/0x01/0x02) and the response codes (0x00/0x09/0x0A/0x1F/0xEE).
REQ-036 A single sub-module, sensor_checksum, SHALL perform the bit-reversal and the 8-bit sum compare combinationally, feeding the CHECK state.

Verification
REQ-037 CMD=0x01; decoder model raises WAIT 1 cycle after DEC_RST and drops it 100 cycles later; raw HUM_INT=0xEC, HUM_FLOAT=0x00, TEMP_INT=0x98, TEMP_FLOAT=0x00, CRC=0x0A; TX_READY=1 -> TX sequence 0x09, 0x19.
REQ-038 Same stimulus with CMD=0x02 and raw CRC=0x0B -> 0x1F, 0x00; a following status command -> 0x1F, 0x00; result registers keep their previous values.
REQ-039 WAIT never rises -> after 16 cycles in WAIT_BUSY, response 0x1F, 0x00.
REQ-040 CMD=0x07 -> 0xEE, 0x00 with DEC_RST never pulsed.
REQ-041 TX_READY held low for 50 cycles during SEND0 -> TX_DATA and TX_VALID stable throughout; a CMD_VALID pulse issued meanwhile is dropped.
REQ-042 RST asserted in WAIT_DONE -> IDLE, CMD_READY=1, TX_VALID=0 and DEC_EN=0 in the same cycle.
